// File: rtl/binning_pkg.sv
// rtl/binning_pkg.sv - shared types and elaboration helpers for the binning downsampler
package binning_pkg;

    typedef enum logic [1:0] {
        MODE_AVG_TRUNC = 2'd0,
        MODE_AVG_ROUND = 2'd1,
        MODE_MAX       = 2'd2,
        MODE_MIN       = 2'd3
    } mode_t;

    // Size of the last (possibly partial) bin along one axis.
    function automatic int final_dim(input int img, input int bin);
        return ((img - 1) % bin) + 1;
    endfunction

    function automatic int acc_width(input int dw, input int bw, input int bh);
        return dw + $clog2(bw * bh);
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int div_ceil(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// rtl/bin_line_buffer.sv - dual-port accumulator RAM with registered read and write forwarding
module bin_line_buffer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 160,
    parameter int AW    = 8
) (
    input  logic             i_clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Same-address write wins so consecutive pixels of one bin column see fresh data.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

endmodule

// File: rtl/binning_downsampler.sv
// rtl/binning_downsampler.sv - streaming BIN_WIDTH x BIN_HEIGHT multi-lane image decimator
module binning_downsampler
    import binning_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CHANNELS     = 1,
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int BIN_WIDTH    = 2,
    parameter int BIN_HEIGHT   = 2
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [1:0]                     i_mode,
    input  logic                           i_data_in_valid,
    input  logic                           i_vsync_in,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_data_in,
    output logic                           o_data_out_valid,
    output logic                           o_vsync_out,
    output logic [DATA_WIDTH*CHANNELS-1:0] o_data_out
);

    localparam int FINAL_W = final_dim(IMAGE_WIDTH, BIN_WIDTH);
    localparam int FINAL_H = final_dim(IMAGE_HEIGHT, BIN_HEIGHT);
    localparam int NBX     = div_ceil(IMAGE_WIDTH, BIN_WIDTH);
    localparam int NBY     = div_ceil(IMAGE_HEIGHT, BIN_HEIGHT);
    localparam int ACC_W   = acc_width(DATA_WIDTH, BIN_WIDTH, BIN_HEIGHT);
    localparam int ACCP    = ACC_W + 1;
    localparam int IXW     = cnt_width(BIN_WIDTH);
    localparam int IYW     = cnt_width(BIN_HEIGHT);
    localparam int BXW     = cnt_width(NBX);
    localparam int BYW     = cnt_width(NBY);
    localparam int PW      = DATA_WIDTH * CHANNELS;
    localparam int LW      = ACC_W * CHANNELS;

    localparam logic [ACCP-1:0] DIV_FULL = ACCP'(BIN_WIDTH * BIN_HEIGHT);
    localparam logic [ACCP-1:0] DIV_COL  = ACCP'(FINAL_W * BIN_HEIGHT);
    localparam logic [ACCP-1:0] DIV_ROW  = ACCP'(BIN_WIDTH * FINAL_H);
    localparam logic [ACCP-1:0] DIV_CORN = ACCP'(FINAL_W * FINAL_H);

    logic [IXW-1:0] r_ix, w_cur_ix, w_nxt_ix;
    logic [IYW-1:0] r_iy, w_cur_iy, w_nxt_iy;
    logic [BXW-1:0] r_bx, w_cur_bx, w_nxt_bx;
    logic [BYW-1:0] r_by, w_cur_by, w_nxt_by;
    mode_t          r_mode, w_cur_mode;
    logic           w_last_col, w_last_row, w_end_x, w_end_y, w_seed, w_bin_done;

    logic           r_s1_valid, r_s1_seed, r_s1_last;
    logic [1:0]     r_s1_cnt_sel;
    logic [BXW-1:0] r_s1_addr;
    mode_t          r_s1_mode;
    logic [PW-1:0]  r_s1_pix;

    logic           r_s2_valid;
    logic [1:0]     r_s2_cnt_sel;
    mode_t          r_s2_mode;
    logic [LW-1:0]  r_s2_acc;

    logic           r_vs1, r_vs2;
    logic [LW-1:0]  w_rdata, w_acc_all;
    logic [PW-1:0]  w_res_all;
    logic           w_we, w_round, w_avg;

    // A vsync zeroes the position in the same cycle, so a coincident pixel is (0,0).
    always_comb begin
        w_cur_ix   = i_vsync_in ? '0 : r_ix;
        w_cur_iy   = i_vsync_in ? '0 : r_iy;
        w_cur_bx   = i_vsync_in ? '0 : r_bx;
        w_cur_by   = i_vsync_in ? '0 : r_by;
        w_cur_mode = i_vsync_in ? mode_t'(i_mode) : r_mode;
        w_last_col = (w_cur_bx == BXW'(NBX - 1));
        w_last_row = (w_cur_by == BYW'(NBY - 1));
        w_end_x    = (w_cur_ix == (w_last_col ? IXW'(FINAL_W - 1) : IXW'(BIN_WIDTH - 1)));
        w_end_y    = (w_cur_iy == (w_last_row ? IYW'(FINAL_H - 1) : IYW'(BIN_HEIGHT - 1)));
        w_seed     = (w_cur_ix == '0) && (w_cur_iy == '0);
        w_bin_done = w_end_x && w_end_y;

        w_nxt_ix = w_cur_ix;
        w_nxt_iy = w_cur_iy;
        w_nxt_bx = w_cur_bx;
        w_nxt_by = w_cur_by;
        if (i_data_in_valid) begin
            if (!w_end_x) begin
                w_nxt_ix = w_cur_ix + 1'b1;
            end else begin
                w_nxt_ix = '0;
                if (!w_last_col) begin
                    w_nxt_bx = w_cur_bx + 1'b1;
                end else begin
                    w_nxt_bx = '0;
                    if (!w_end_y) begin
                        w_nxt_iy = w_cur_iy + 1'b1;
                    end else begin
                        w_nxt_iy = '0;
                        w_nxt_by = w_last_row ? '0 : w_cur_by + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ix         <= '0;
            r_iy         <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_mode       <= MODE_AVG_TRUNC;
            r_s1_valid   <= 1'b0;
            r_s1_seed    <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_cnt_sel <= '0;
            r_s1_addr    <= '0;
            r_s1_mode    <= MODE_AVG_TRUNC;
            r_s1_pix     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_cnt_sel <= '0;
            r_s2_mode    <= MODE_AVG_TRUNC;
            r_s2_acc     <= '0;
            r_vs1        <= 1'b0;
            r_vs2        <= 1'b0;
            o_vsync_out  <= 1'b0;
            o_data_out_valid <= 1'b0;
            o_data_out   <= '0;
        end else begin
            r_ix         <= w_nxt_ix;
            r_iy         <= w_nxt_iy;
            r_bx         <= w_nxt_bx;
            r_by         <= w_nxt_by;
            r_mode       <= w_cur_mode;
            r_s1_valid   <= i_data_in_valid;
            r_s1_seed    <= w_seed;
            r_s1_last    <= w_bin_done;
            r_s1_cnt_sel <= {w_last_row, w_last_col};
            r_s1_addr    <= w_cur_bx;
            r_s1_mode    <= w_cur_mode;
            r_s1_pix     <= i_data_in;
            r_s2_valid   <= r_s1_valid && r_s1_last;
            r_s2_cnt_sel <= r_s1_cnt_sel;
            r_s2_mode    <= r_s1_mode;
            r_s2_acc     <= w_acc_all;
            r_vs1        <= i_vsync_in;
            r_vs2        <= r_vs1;
            o_vsync_out  <= r_vs2;
            o_data_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                o_data_out <= w_res_all;
            end
        end
    end

    // Completed bins never write back; their column is reseeded by the next bin row.
    assign w_we = r_s1_valid && !r_s1_last;

    bin_line_buffer #(
        .WIDTH (LW),
        .DEPTH (NBX),
        .AW    (BXW)
    ) u_line_buffer (
        .i_clock (i_clock),
        .i_we    (w_we),
        .i_waddr (r_s1_addr),
        .i_wdata (w_acc_all),
        .i_raddr (w_cur_bx),
        .o_rdata (w_rdata)
    );

    assign w_round = (r_s2_mode == MODE_AVG_ROUND);
    assign w_avg   = (r_s2_mode == MODE_AVG_TRUNC) || w_round;

    for (genvar l = 0; l < CHANNELS; l++) begin : g_lane
        logic [ACC_W-1:0]      w_rd, w_px, w_acc;
        logic [ACCP-1:0]       w_sum;
        logic [DATA_WIDTH-1:0] w_res;

        assign w_rd  = w_rdata[l*ACC_W +: ACC_W];
        assign w_px  = ACC_W'(r_s1_pix[l*DATA_WIDTH +: DATA_WIDTH]);
        assign w_sum = {1'b0, r_s2_acc[l*ACC_W +: ACC_W]};

        always_comb begin
            w_acc = w_px;
            if (!r_s1_seed) begin
                case (r_s1_mode)
                    MODE_MAX: w_acc = (w_px > w_rd) ? w_px : w_rd;
                    MODE_MIN: w_acc = (w_px < w_rd) ? w_px : w_rd;
                    default:  w_acc = w_rd + w_px;
                endcase
            end
        end

        // Each bin shape has its own constant divisor.
        always_comb begin
            w_res = r_s2_acc[l*ACC_W +: DATA_WIDTH];
            if (w_avg) begin
                case (r_s2_cnt_sel)
                    2'b00:   w_res = DATA_WIDTH'((w_sum + (w_round ? (DIV_FULL >> 1) : '0)) / DIV_FULL);
                    2'b01:   w_res = DATA_WIDTH'((w_sum + (w_round ? (DIV_COL  >> 1) : '0)) / DIV_COL);
                    2'b10:   w_res = DATA_WIDTH'((w_sum + (w_round ? (DIV_ROW  >> 1) : '0)) / DIV_ROW);
                    default: w_res = DATA_WIDTH'((w_sum + (w_round ? (DIV_CORN >> 1) : '0)) / DIV_CORN);
                endcase
            end
        end

        assign w_acc_all[l*ACC_W +: ACC_W]           = w_acc;
        assign w_res_all[l*DATA_WIDTH +: DATA_WIDTH] = w_res;
    end

endmodule

// File: tb/tb_binning_downsampler.sv
// tb/tb_binning_downsampler.sv - self-checking bench for binning_downsampler
module tb_binning_downsampler;
    import binning_pkg::*;

    localparam int BW = 2;
    localparam int BH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]  a_mode, b_mode;
    logic        a_v, a_vs, b_v, b_vs;
    logic [23:0] a_d, a_od;
    logic [7:0]  b_d, b_od;
    logic        a_ov, a_ovs, b_ov, b_ovs;

    binning_downsampler #(.DATA_WIDTH(8), .CHANNELS(3), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
                          .BIN_WIDTH(2), .BIN_HEIGHT(2)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_mode(a_mode), .i_data_in_valid(a_v),
        .i_vsync_in(a_vs), .i_data_in(a_d), .o_data_out_valid(a_ov),
        .o_vsync_out(a_ovs), .o_data_out(a_od));

    binning_downsampler #(.DATA_WIDTH(8), .CHANNELS(1), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
                          .BIN_WIDTH(2), .BIN_HEIGHT(2)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_mode(b_mode), .i_data_in_valid(b_v),
        .i_vsync_in(b_vs), .i_data_in(b_d), .o_data_out_valid(b_ov),
        .o_vsync_out(b_ovs), .o_data_out(b_od));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] pix [25];
    int          pedge [25];
    logic [23:0] exp_d[$], obs_a_d[$], obs_b_d[$], got_d[$];
    int          exp_c[$], obs_a_c[$], obs_b_c[$], got_c[$];
    int          exp_vs[$], obs_a_vs[$], obs_b_vs[$], got_vs[$];
    logic [23:0] last_exp;
    int          checks = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (a_ov === 1'b1) begin obs_a_d.push_back(a_od); obs_a_c.push_back(cyc); end
        if (a_ovs === 1'b1) obs_a_vs.push_back(cyc);
        if (b_ov === 1'b1) begin obs_b_d.push_back({16'h0, b_od}); obs_b_c.push_back(cyc); end
        if (b_ovs === 1'b1) obs_b_vs.push_back(cyc);
    end

    task automatic drive(input int d, input logic v, input logic vs, input logic [1:0] md,
                         input logic [23:0] px);
        if (d == 0) begin a_v = v; a_vs = vs; a_mode = md; a_d = px; end
        else begin b_v = v; b_vs = vs; b_mode = md; b_d = px[7:0]; end
    endtask

    // Mode input is randomised except on the vsync cycle, so only latching can give the right mode.
    task automatic run_frame(input int d, input int npix, input logic [1:0] md,
                             input bit vs_first, input int gap_pct);
        for (int i = 0; i < npix; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                drive(d, 1'b0, 1'b0, 2'($urandom), 24'($urandom));
                @(negedge clk);
            end
            drive(d, 1'b1, vs_first && (i == 0), (i == 0) ? md : 2'($urandom), pix[i]);
            pedge[i] = cyc + 1;
            if (vs_first && i == 0) exp_vs.push_back(cyc + 3);
            @(negedge clk);
        end
        drive(d, 1'b0, 1'b0, 2'($urandom), 24'($urandom));
    endtask

    task automatic ref_frame(input int w, input int h, input int ch_n, input logic [1:0] md);
        for (int by = 0; by * BH < h; by++) begin
            for (int bx = 0; bx * BW < w; bx++) begin
                int rows, cols, cnt;
                logic [23:0] r;
                rows = (h - by * BH >= BH) ? BH : h - by * BH;
                cols = (w - bx * BW >= BW) ? BW : w - bx * BW;
                cnt  = rows * cols;
                r    = '0;
                for (int c = 0; c < ch_n; c++) begin
                    int sum, mx, mn, v, res;
                    sum = 0; mx = 0; mn = 255;
                    for (int yy = 0; yy < rows; yy++)
                        for (int xx = 0; xx < cols; xx++) begin
                            v = int'(pix[(by * BH + yy) * w + bx * BW + xx][c*8 +: 8]);
                            sum += v;
                            if (v > mx) mx = v;
                            if (v < mn) mn = v;
                        end
                    case (md)
                        2'd0:    res = sum / cnt;
                        2'd1:    res = (sum + cnt / 2) / cnt;
                        2'd2:    res = mx;
                        default: res = mn;
                    endcase
                    r[c*8 +: 8] = 8'(res);
                end
                exp_d.push_back(r);
                exp_c.push_back(pedge[(by * BH + rows - 1) * w + bx * BW + cols - 1] + 2);
            end
        end
    endtask

    task automatic collect(input int d);
        repeat (5) @(negedge clk);
        if (d == 0) begin
            got_d = obs_a_d; got_c = obs_a_c; got_vs = obs_a_vs;
            obs_a_d.delete(); obs_a_c.delete(); obs_a_vs.delete();
        end else begin
            got_d = obs_b_d; got_c = obs_b_c; got_vs = obs_b_vs;
            obs_b_d.delete(); obs_b_c.delete(); obs_b_vs.delete();
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        checks++;
        assert (got_d.size() === exp_d.size()) else begin
            failures++;
            $error("FAIL %s out_count got=%0d exp=%0d", tag, got_d.size(), exp_d.size());
        end
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (got_d[i] === exp_d[i]) else begin
                failures++;
                $error("FAIL %s data[%0d] got=%h exp=%h", tag, i, got_d[i], exp_d[i]);
            end
            checks++;
            assert (got_c[i] === exp_c[i]) else begin
                failures++;
                $error("FAIL %s cycle[%0d] got=%0d exp=%0d", tag, i, got_c[i], exp_c[i]);
            end
        end
        checks++;
        assert (got_vs.size() === exp_vs.size()) else begin
            failures++;
            $error("FAIL %s vsync_count got=%0d exp=%0d", tag, got_vs.size(), exp_vs.size());
        end
        n = (got_vs.size() < exp_vs.size()) ? got_vs.size() : exp_vs.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (got_vs[i] === exp_vs[i]) else begin
                failures++;
                $error("FAIL %s vsync_cycle[%0d] got=%0d exp=%0d", tag, i, got_vs[i], exp_vs[i]);
            end
        end
        if (exp_d.size() > 0) last_exp = exp_d[exp_d.size() - 1];
        exp_d.delete(); exp_c.delete(); exp_vs.delete();
    endtask

    task automatic check_val(input string tag, input int idx, input logic [23:0] mask,
                             input logic [23:0] want);
        logic [23:0] o;
        o = (idx < got_d.size()) ? (got_d[idx] & mask) : 24'hxxxxxx;
        checks++;
        assert (o === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, o, want);
        end
    endtask

    task automatic check_sig(input string tag, input logic [23:0] obs, input logic [23:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 24'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 24'h0);
        #12;
        check_sig("reset_a_valid", {23'h0, a_ov}, 24'h0);
        check_sig("reset_a_vsync", {23'h0, a_ovs}, 24'h0);
        check_sig("reset_a_data", a_od, 24'h0);
        check_sig("reset_b_valid", {23'h0, b_ov}, 24'h0);
        check_sig("reset_b_data", {16'h0, b_od}, 24'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // In-order truncating mean, then the same frame with valid gaps
        for (int i = 0; i < 16; i++) pix[i] = {8'($urandom), 8'(i + 100), 8'(i)};
        run_frame(0, 16, MODE_AVG_TRUNC, 1'b1, 0);
        ref_frame(4, 4, 3, MODE_AVG_TRUNC);
        collect(0);
        compare_model("trunc_inorder");
        check_val("trunc_b0", 0, 24'hFF, 24'd2);
        check_val("trunc_b1", 1, 24'hFF, 24'd4);
        check_val("trunc_b2", 2, 24'hFF, 24'd10);
        check_val("trunc_b3", 3, 24'hFF, 24'd12);

        run_frame(0, 16, MODE_AVG_TRUNC, 1'b1, 50);
        ref_frame(4, 4, 3, MODE_AVG_TRUNC);
        collect(0);
        compare_model("trunc_gaps");
        check_val("gaps_b0", 0, 24'hFF, 24'd2);
        check_val("gaps_b3", 3, 24'hFF, 24'd12);

        // Round vs truncate on 1,2,2,2, plus a back-to-back frame with no vsync
        for (int i = 0; i < 16; i++) pix[i] = 24'($urandom);
        pix[0] = 24'h010101; pix[1] = 24'h020202; pix[4] = 24'h020202; pix[5] = 24'h020202;
        run_frame(0, 16, MODE_AVG_ROUND, 1'b1, 0);
        ref_frame(4, 4, 3, MODE_AVG_ROUND);
        run_frame(0, 16, MODE_AVG_TRUNC, 1'b1, 0);
        ref_frame(4, 4, 3, MODE_AVG_TRUNC);
        for (int i = 0; i < 16; i++) pix[i] = 24'($urandom);
        run_frame(0, 16, MODE_MAX, 1'b0, 0);
        ref_frame(4, 4, 3, MODE_AVG_TRUNC);
        collect(0);
        compare_model("round_trunc");
        check_val("round_1222", 0, 24'hFFFFFF, 24'h020202);
        check_val("trunc_1222", 4, 24'hFFFFFF, 24'h010101);

        // Multi-lane max then min
        for (int i = 0; i < 16; i++) pix[i] = 24'($urandom);
        pix[0] = {3{8'd10}}; pix[1] = {3{8'd200}}; pix[4] = {3{8'd7}}; pix[5] = {3{8'd99}};
        run_frame(0, 16, MODE_MAX, 1'b1, 0);
        ref_frame(4, 4, 3, MODE_MAX);
        run_frame(0, 16, MODE_MIN, 1'b1, 30);
        ref_frame(4, 4, 3, MODE_MIN);
        collect(0);
        compare_model("max_min");
        check_val("max_lanes", 0, 24'hFFFFFF, 24'hC8C8C8);
        check_val("min_lanes", 4, 24'hFFFFFF, 24'h070707);

        // Partial edge bins on 5x5
        for (int i = 0; i < 25; i++) pix[i] = 24'hFF;
        run_frame(1, 25, MODE_AVG_ROUND, 1'b1, 0);
        ref_frame(5, 5, 1, MODE_AVG_ROUND);
        for (int i = 0; i < 25; i++) pix[i] = 24'($urandom_range(0, 255));
        run_frame(1, 25, MODE_AVG_TRUNC, 1'b1, 40);
        ref_frame(5, 5, 1, MODE_AVG_TRUNC);
        collect(1);
        compare_model("edge_5x5");
        for (int k = 0; k < 9; k++) check_val("edge_255", k, 24'hFF, 24'hFF);

        // Resync: aborted 6-pixel frame, then a MAX frame
        for (int i = 0; i < 25; i++) pix[i] = 24'($urandom_range(0, 255));
        run_frame(1, 6, MODE_AVG_TRUNC, 1'b1, 0);
        for (int i = 0; i < 25; i++) pix[i] = 24'($urandom_range(0, 255));
        run_frame(1, 25, MODE_MAX, 1'b1, 0);
        ref_frame(5, 5, 1, MODE_MAX);
        collect(1);
        compare_model("resync_max");

        // Reset mid-bin while a pixel is valid
        for (int i = 0; i < 16; i++) pix[i] = 24'($urandom) | 24'h010101;
        run_frame(0, 16, MODE_AVG_TRUNC, 1'b1, 0);
        ref_frame(4, 4, 3, MODE_AVG_TRUNC);
        collect(0);
        compare_model("pre_reset");
        check_sig("hold_between_valids", a_od, last_exp);
        run_frame(0, 3, MODE_AVG_ROUND, 1'b1, 0);
        drive(0, 1'b1, 1'b0, 2'd1, pix[3]);
        #2 rst = 1'b1;
        #1;
        check_sig("midreset_data", a_od, 24'h0);
        check_sig("midreset_valid", {23'h0, a_ov}, 24'h0);
        check_sig("midreset_vsync", {23'h0, a_ovs}, 24'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 2'd0, 24'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) pix[i] = 24'($urandom);
        run_frame(0, 16, MODE_MAX, 1'b0, 0);
        ref_frame(4, 4, 3, MODE_AVG_TRUNC);
        collect(0);
        compare_model("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
